// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network layer controller.
//   SNN_SIZE       : default datapath width (sign-magnitude weights, MSB = sign)
//   FSEL_ADD/DECAY : encodings of the neuron datapath function select
//   sched_state_t  : scheduler FSM states, also published on dbg_state
package snn_pkg;

  localparam int SNN_SIZE = 8;

  localparam logic FSEL_ADD   = 1'b0;
  localparam logic FSEL_DECAY = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_ACC   = 3'd2,
    ST_DECAY = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/vmem_regfile.sv
// Membrane-potential storage for one layer: NUM_OUT entries of SIZE bits.
//   clk, rst_n : clock, asynchronous active-low reset (all entries to 0)
//   clr        : synchronous clear of every entry (wins over we)
//   we, waddr, wdata : single write port
//   raddr, rdata     : single combinational read port
module vmem_regfile
  import snn_pkg::*;
#(
  parameter int SIZE    = SNN_SIZE,
  parameter int NUM_OUT = 4,
  parameter int AW      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [SIZE-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [SIZE-1:0] rdata
);

  logic [NUM_OUT-1:0][SIZE-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (clr) begin
      mem <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/neuron_scheduler.sv
// Layer controller for the shared combinational neuron datapath.
// On an accepted start it samples in_spikes, walks every (output j, input i)
// pair, accumulates the weight of each active input through the datapath in
// add mode, then runs one decay/threshold step per output neuron.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, clear_vmem    : IDLE-only controls (clear wins over start)
//   in_spikes            : input spike vector, captured on accepted start
//   busy, done           : run in progress / one-cycle completion pulse
//   out_spikes           : registered layer output spikes
//   w_addr, w_rdata      : weight memory port (1-cycle read latency)
//   n_weight, n_v_mem_in, n_function_sel : datapath operands
//   n_v_mem_out, n_spike : datapath results
//   dbg_state            : current FSM state (snn_pkg::sched_state_t)
//
// Control handshake: start and clear_vmem are single-cycle level requests
// sampled only in IDLE; there is no ready/ack, so a request raised while busy
// is dropped rather than held. done is a pulse, not a level.
module neuron_scheduler
  import snn_pkg::*;
#(
  parameter int SIZE    = SNN_SIZE,
  parameter int NUM_IN  = 16,
  parameter int NUM_OUT = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               clear_vmem,
  input  logic [NUM_IN-1:0]                  in_spikes,
  output logic                               busy,
  output logic                               done,
  output logic [NUM_OUT-1:0]                 out_spikes,
  output logic [$clog2(NUM_OUT*NUM_IN)-1:0]  w_addr,
  input  logic [SIZE-1:0]                    w_rdata,
  output logic [SIZE-1:0]                    n_weight,
  output logic [SIZE-1:0]                    n_v_mem_in,
  output logic                               n_function_sel,
  input  logic [SIZE-1:0]                    n_v_mem_out,
  input  logic                               n_spike,
  output logic [2:0]                         dbg_state
);

  localparam int AW = $clog2(NUM_OUT*NUM_IN);
  localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int JW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  sched_state_t      state_q, state_d;
  logic [NUM_IN-1:0] spk_q;
  logic [IW-1:0]     i_q;
  logic [JW-1:0]     j_q;

  logic            last_i, last_j, cur_spk;
  logic            accept_start, do_clear, vm_we, inc_i, decay_step;
  logic [SIZE-1:0] vmem_rd;

  assign last_i  = (i_q == IW'(NUM_IN - 1));
  assign last_j  = (j_q == JW'(NUM_OUT - 1));
  assign cur_spk = spk_q[i_q];

  // Address is a pure function of the walk counters; it is meaningful in SCAN,
  // where the synchronous weight memory registers it for use in ACC.
  assign w_addr     = AW'(j_q) * AW'(NUM_IN) + AW'(i_q);
  assign n_v_mem_in = vmem_rd;
  assign dbg_state  = state_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-state outputs
  always_comb begin
    state_d        = state_q;
    busy           = 1'b0;
    done           = 1'b0;
    n_weight       = '0;
    n_function_sel = FSEL_ADD;
    accept_start   = 1'b0;
    do_clear       = 1'b0;
    vm_we          = 1'b0;
    inc_i          = 1'b0;
    decay_step     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_vmem) begin
          do_clear = 1'b1;
        end else if (start) begin
          accept_start = 1'b1;
          state_d      = ST_SCAN;
        end
      end
      ST_SCAN: begin
        busy = 1'b1;
        if (cur_spk) begin
          state_d = ST_ACC;
        end else begin
          inc_i = 1'b1;
          if (last_i) state_d = ST_DECAY;
        end
      end
      ST_ACC: begin
        busy           = 1'b1;
        n_weight       = w_rdata;
        n_function_sel = FSEL_ADD;
        vm_we          = 1'b1;
        inc_i          = 1'b1;
        state_d        = last_i ? ST_DECAY : ST_SCAN;
      end
      ST_DECAY: begin
        busy           = 1'b1;
        n_function_sel = FSEL_DECAY;
        vm_we          = 1'b1;
        decay_step     = 1'b1;
        state_d        = last_j ? ST_DONE : ST_SCAN;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Walk counters, sampled spikes and output spike register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spk_q      <= '0;
      i_q        <= '0;
      j_q        <= '0;
      out_spikes <= '0;
    end else begin
      if (accept_start) begin
        spk_q      <= in_spikes;
        out_spikes <= '0;
        i_q        <= '0;
        j_q        <= '0;
      end
      // Wrap explicitly so i never indexes past spk_q when NUM_IN is not a
      // power of two.
      if (inc_i) begin
        i_q <= last_i ? '0 : i_q + IW'(1);
      end
      if (decay_step) begin
        out_spikes[j_q] <= n_spike;
        if (!last_j) begin
          j_q <= j_q + JW'(1);
          i_q <= '0;
        end
      end
    end
  end

  vmem_regfile #(
    .SIZE    (SIZE),
    .NUM_OUT (NUM_OUT),
    .AW      (JW)
  ) u_vmem (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (do_clear),
    .we    (vm_we),
    .waddr (j_q),
    .wdata (n_v_mem_out),
    .raddr (j_q),
    .rdata (vmem_rd)
  );

endmodule

// File: tb/tb_neuron_scheduler.sv
// Bench for neuron_scheduler with NUM_IN=4, NUM_OUT=2, a behavioural neuron
// datapath (beta=0xFF, v_th=0x40) and a 1-cycle synchronous weight memory.
module tb_neuron_scheduler;
  import snn_pkg::*;

  localparam int SIZE    = 8;
  localparam int NUM_IN  = 4;
  localparam int NUM_OUT = 2;
  localparam int AW      = 3;
  localparam int BETA    = 255;
  localparam int V_TH    = 64;

  logic            clk, rst_n, start, clear_vmem;
  logic [3:0]      in_spikes;
  logic            busy, done;
  logic [1:0]      out_spikes;
  logic [AW-1:0]   w_addr;
  logic [7:0]      w_rdata, n_weight, n_v_mem_in, n_v_mem_out;
  logic            n_function_sel, n_spike;
  logic [2:0]      dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] wmem [8];
  int         model_vmem [2];

  // scoreboard expectations
  logic [AW-1:0] exp_addr_q [$];
  logic [7:0]    exp_wt_q [$];
  logic [7:0]    exp_pre_q [$];
  int            exp_cycles;
  logic [1:0]    exp_spikes;

  // observations collected by the driver
  logic [AW-1:0] obs_addr_q [$];
  logic [7:0]    obs_wt_q [$];
  logic [7:0]    obs_pre_q [$];
  int            obs_cycles;
  logic [1:0]    obs_spikes;
  logic [7:0]    obs_vmem_last;
  logic          obs_done_after;
  int            obs_bad_ctrl;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- DUT and environment ----------------
  neuron_scheduler #(.SIZE(SIZE), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .clear_vmem     (clear_vmem),
    .in_spikes      (in_spikes),
    .busy           (busy),
    .done           (done),
    .out_spikes     (out_spikes),
    .w_addr         (w_addr),
    .w_rdata        (w_rdata),
    .n_weight       (n_weight),
    .n_v_mem_in     (n_v_mem_in),
    .n_function_sel (n_function_sel),
    .n_v_mem_out    (n_v_mem_out),
    .n_spike        (n_spike),
    .dbg_state      (dbg_state)
  );

  always @(posedge clk) w_rdata <= wmem[w_addr];

  // Neuron datapath behaviour: saturating sign-magnitude add, or
  // multiplicative decay followed by threshold with reset-to-zero on spike.
  function automatic logic [8:0] dp_eval(input logic fsel, input logic [7:0] vin,
                                         input logic [7:0] w);
    int v;
    if (fsel == 1'b0) begin
      if (w[7]) v = int'(vin) - int'(w[6:0]);
      else      v = int'(vin) + int'(w[6:0]);
      if (v < 0)   v = 0;
      if (v > 255) v = 255;
      return {1'b0, 8'(v)};
    end
    v = (int'(vin) * BETA) / 256;
    if (v > V_TH) return {1'b1, 8'h00};
    return {1'b0, 8'(v)};
  endfunction

  always_comb {n_spike, n_v_mem_out} = dp_eval(n_function_sel, n_v_mem_in, n_weight);

  // ---------------- reference model ----------------
  task automatic model_timestep(input logic [3:0] sp);
    logic [8:0] r;
    exp_addr_q.delete();
    exp_wt_q.delete();
    exp_pre_q.delete();
    exp_spikes = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (sp[i]) begin
          exp_addr_q.push_back(AW'(j * NUM_IN + i));
          exp_wt_q.push_back(wmem[j * NUM_IN + i]);
          r = dp_eval(1'b0, 8'(model_vmem[j]), wmem[j * NUM_IN + i]);
          model_vmem[j] = int'(r[7:0]);
        end
      end
      exp_pre_q.push_back(8'(model_vmem[j]));
      r = dp_eval(1'b1, 8'(model_vmem[j]), 8'h00);
      model_vmem[j] = int'(r[7:0]);
      exp_spikes[j] = r[8];
    end
    exp_cycles = NUM_OUT * (NUM_IN + $countones(sp) + 1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_vmem[0] = 0;
    model_vmem[1] = 0;
  endtask

  // Runs one timestep. Cycle k=0 is the first SCAN cycle; when done is seen
  // obs_cycles=k. poke_at>=0 raises start and clear_vmem during that busy
  // cycle. Ends sampled in the IDLE cycle right after DONE.
  task automatic run_timestep(input logic [3:0] sp, input int poke_at);
    obs_addr_q.delete();
    obs_wt_q.delete();
    obs_pre_q.delete();
    obs_cycles   = -1;
    obs_spikes   = 2'bxx;
    obs_bad_ctrl = 0;
    @(negedge clk);
    in_spikes = sp;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    in_spikes = 4'($urandom_range(0, 15));
    for (int k = 0; k < 100; k++) begin
      if (k == poke_at) begin
        start      = 1'b1;
        clear_vmem = 1'b1;
      end else begin
        start      = 1'b0;
        clear_vmem = 1'b0;
      end
      case (dbg_state)
        ST_ACC: begin
          obs_addr_q.push_back(w_addr);
          obs_wt_q.push_back(n_weight);
          if (n_function_sel !== FSEL_ADD) obs_bad_ctrl++;
        end
        ST_DECAY: begin
          obs_pre_q.push_back(n_v_mem_in);
          if (n_function_sel !== FSEL_DECAY || n_weight !== 8'h00) obs_bad_ctrl++;
        end
        default: begin
          if (n_function_sel !== 1'b0 || n_weight !== 8'h00) obs_bad_ctrl++;
        end
      endcase
      if (busy !== 1'b1) obs_bad_ctrl++;
      if (done === 1'b1) begin
        obs_cycles = k;
        obs_spikes = out_spikes;
        break;
      end
      @(posedge clk);
      #1;
    end
    start      = 1'b0;
    clear_vmem = 1'b0;
    @(posedge clk);
    #1;
    obs_vmem_last  = n_v_mem_in;
    obs_done_after = done;
    if (busy !== 1'b0) obs_bad_ctrl++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_errors++; $display("FAIL reset_busy_done: got %b expected 00", {busy, done});
    end
    n_checks++;
    if (out_spikes !== 2'b00 || w_addr !== 3'd0) begin
      n_errors++; $display("FAIL reset_spk_addr: got spikes=%b addr=%0d expected 0/0", out_spikes, w_addr);
    end
    n_checks++;
    if (n_weight !== 8'h00 || n_function_sel !== 1'b0) begin
      n_errors++; $display("FAIL reset_operands: got w=%h fsel=%b expected 00/0", n_weight, n_function_sel);
    end
    n_checks++;
    if (n_v_mem_in !== 8'h00 || dbg_state !== ST_IDLE) begin
      n_errors++; $display("FAIL reset_vmem_state: got vmem=%h state=%0d expected 00/IDLE", n_v_mem_in, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_vmem[0] = 0;
    model_vmem[1] = 0;
  endtask

  task automatic test_all_zero();
    for (int k = 0; k < 8; k++) wmem[k] = 8'($urandom_range(1, 127));
    model_timestep(4'b0000);
    run_timestep(4'b0000, -1);
    n_checks++;
    if (obs_cycles !== 10) begin
      n_errors++; $display("FAIL zero_cycles: got %0d expected 10", obs_cycles);
    end
    n_checks++;
    if (obs_addr_q.size() != 0) begin
      n_errors++; $display("FAIL zero_no_acc: got %0d ACC cycles expected 0", obs_addr_q.size());
    end
    n_checks++;
    if (obs_spikes !== 2'b00 || obs_vmem_last !== 8'h00) begin
      n_errors++; $display("FAIL zero_result: got spikes=%b vmem1=%h expected 00/00", obs_spikes, obs_vmem_last);
    end
    n_checks++;
    if (obs_pre_q.size() != 2 || obs_pre_q[0] !== 8'h00 || obs_pre_q[1] !== 8'h00) begin
      n_errors++; $display("FAIL zero_decays: got %0d decay steps expected 2 with vmem 00", obs_pre_q.size());
    end
    n_checks++;
    if (obs_bad_ctrl != 0 || obs_done_after !== 1'b0) begin
      n_errors++; $display("FAIL zero_ctrl: got bad=%0d done_after=%b expected 0/0", obs_bad_ctrl, obs_done_after);
    end
  endtask

  task automatic test_sub_threshold();
    logic [AW-1:0] want_addr [4];
    want_addr = '{3'd0, 3'd2, 3'd4, 3'd6};
    for (int k = 0; k < 8; k++) wmem[k] = 8'h10;
    model_timestep(4'b0101);
    run_timestep(4'b0101, -1);
    n_checks++;
    if (obs_cycles !== 14) begin
      n_errors++; $display("FAIL sub_cycles: got %0d expected 14", obs_cycles);
    end
    n_checks++;
    if (obs_addr_q.size() != 4) begin
      n_errors++; $display("FAIL sub_addr_count: got %0d expected 4", obs_addr_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (obs_addr_q[k] !== want_addr[k] || obs_wt_q[k] !== 8'h10) begin
          n_errors++;
          $display("FAIL sub_addr[%0d]: got addr=%0d w=%h expected %0d/10", k, obs_addr_q[k], obs_wt_q[k], want_addr[k]);
        end
      end
    end
    n_checks++;
    if (obs_spikes !== 2'b00 || obs_vmem_last !== 8'h1F) begin
      n_errors++; $display("FAIL sub_result: got spikes=%b vmem1=%h expected 00/1F", obs_spikes, obs_vmem_last);
    end
    // vmem0 is only visible again when the next run decays neuron 0
    model_timestep(4'b0000);
    run_timestep(4'b0000, -1);
    n_checks++;
    if (obs_pre_q.size() != 2 || obs_pre_q[0] !== 8'h1F || obs_pre_q[1] !== 8'h1F) begin
      n_errors++; $display("FAIL sub_vmem_kept: got %p expected 1F,1F", obs_pre_q);
    end
  endtask

  task automatic test_firing();
    do_reset();
    for (int k = 0; k < 8; k++) wmem[k] = 8'h10;
    wmem[0] = 8'h30;
    wmem[1] = 8'h30;
    model_timestep(4'b0011);
    run_timestep(4'b0011, -1);
    n_checks++;
    if (obs_pre_q.size() != 2 || obs_pre_q[0] !== 8'h60 || obs_pre_q[1] !== 8'h20) begin
      n_errors++; $display("FAIL fire_accum: got %p expected 60,20", obs_pre_q);
    end
    n_checks++;
    if (obs_spikes !== 2'b01) begin
      n_errors++; $display("FAIL fire_spikes: got %b expected 01", obs_spikes);
    end
    model_timestep(4'b0000);
    run_timestep(4'b0000, -1);
    n_checks++;
    if (obs_pre_q.size() != 2 || obs_pre_q[0] !== 8'h00 || obs_pre_q[1] !== 8'h1F) begin
      n_errors++; $display("FAIL fire_vmem_reset: got %p expected 00,1F", obs_pre_q);
    end
  endtask

  task automatic test_negative_weight();
    do_reset();
    for (int k = 0; k < 8; k++) wmem[k] = 8'h85;
    model_timestep(4'b0001);
    run_timestep(4'b0001, -1);
    n_checks++;
    if (obs_wt_q.size() != 2 || obs_wt_q[0] !== 8'h85) begin
      n_errors++; $display("FAIL neg_weight_fed: got %0d ACC cycles expected 2 with weight 85", obs_wt_q.size());
    end
    n_checks++;
    if (obs_pre_q.size() != 2 || obs_pre_q[0] !== 8'h00 || obs_pre_q[1] !== 8'h00) begin
      n_errors++; $display("FAIL neg_clamp: got %p expected 00,00", obs_pre_q);
    end
    n_checks++;
    if (obs_spikes !== 2'b00) begin
      n_errors++; $display("FAIL neg_spikes: got %b expected 00", obs_spikes);
    end
  endtask

  task automatic test_start_while_busy();
    int extra_done, extra_busy;
    logic [3:0] sp;
    for (int k = 0; k < 8; k++) wmem[k] = 8'($urandom_range(0, 60));
    sp = 4'b1011;
    model_timestep(sp);
    run_timestep(sp, 3);
    n_checks++;
    if (obs_cycles !== exp_cycles || obs_spikes !== exp_spikes) begin
      n_errors++; $display("FAIL busy_start_run: got %0d/%b expected %0d/%b", obs_cycles, obs_spikes, exp_cycles, exp_spikes);
    end
    n_checks++;
    if (obs_pre_q.size() != 2 || obs_pre_q[0] !== exp_pre_q[0] || obs_pre_q[1] !== exp_pre_q[1]) begin
      n_errors++; $display("FAIL busy_clear_ignored: got %p expected %p", obs_pre_q, exp_pre_q);
    end
    extra_done = 0;
    extra_busy = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) extra_done++;
      if (busy === 1'b1) extra_busy++;
    end
    n_checks++;
    if (extra_done != 0 || extra_busy != 0) begin
      n_errors++; $display("FAIL busy_not_queued: got done=%0d busy=%0d expected 0/0", extra_done, extra_busy);
    end
  endtask

  task automatic test_clear_with_start();
    int busy_seen;
    for (int k = 0; k < 8; k++) wmem[k] = 8'h10;
    model_vmem[0] = 0;
    model_vmem[1] = 0;
    @(negedge clk);
    clear_vmem = 1'b1;
    @(negedge clk);
    clear_vmem = 1'b0;
    model_timestep(4'b1111);
    run_timestep(4'b1111, -1);
    n_checks++;
    if (obs_vmem_last !== 8'h3F) begin
      n_errors++; $display("FAIL clr_setup: got vmem1=%h expected 3F", obs_vmem_last);
    end
    @(negedge clk);
    clear_vmem = 1'b1;
    start      = 1'b1;
    in_spikes  = 4'b1111;
    @(posedge clk);
    #1;
    clear_vmem = 1'b0;
    start      = 1'b0;
    busy_seen  = 0;
    for (int k = 0; k < 4; k++) begin
      if (busy === 1'b1) busy_seen++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (busy_seen != 0 || n_v_mem_in !== 8'h00) begin
      n_errors++; $display("FAIL clr_start_dropped: got busy=%0d vmem1=%h expected 0/00", busy_seen, n_v_mem_in);
    end
    model_vmem[0] = 0;
    model_vmem[1] = 0;
    model_timestep(4'b0000);
    run_timestep(4'b0000, -1);
    n_checks++;
    if (obs_pre_q.size() != 2 || obs_pre_q[0] !== 8'h00 || obs_pre_q[1] !== 8'h00) begin
      n_errors++; $display("FAIL clr_all_entries: got %p expected 00,00", obs_pre_q);
    end
  endtask

  task automatic test_reset_mid_scan();
    int done_seen;
    for (int k = 0; k < 8; k++) wmem[k] = 8'h10;
    @(negedge clk);
    in_spikes = 4'b1111;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (dbg_state !== ST_IDLE || busy !== 1'b0 || done !== 1'b0) begin
      n_errors++; $display("FAIL rst_mid_idle: got state=%0d busy=%b done=%b expected IDLE/0/0", dbg_state, busy, done);
    end
    n_checks++;
    if (n_v_mem_in !== 8'h00 || out_spikes !== 2'b00) begin
      n_errors++; $display("FAIL rst_mid_vmem: got vmem=%h spikes=%b expected 00/00", n_v_mem_in, out_spikes);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_vmem[0] = 0;
    model_vmem[1] = 0;
    done_seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) begin
      n_errors++; $display("FAIL rst_mid_no_done: got %0d active cycles expected 0", done_seen);
    end
  endtask

  // Consecutive runs start in the IDLE cycle right after DONE; vmem carries
  // over between runs except where a random clear is inserted.
  task automatic test_random_back_to_back();
    logic [3:0] sp;
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 8; k++) wmem[k] = 8'($urandom_range(0, 255));
      sp = 4'($urandom_range(0, 15));
      model_timestep(sp);
      run_timestep(sp, -1);
      n_checks++;
      if (obs_cycles !== exp_cycles || obs_spikes !== exp_spikes) begin
        n_errors++;
        $display("FAIL rand_run%0d_timing: got %0d/%b expected %0d/%b", r, obs_cycles, obs_spikes, exp_cycles, exp_spikes);
      end
      n_checks++;
      if (obs_addr_q.size() != exp_addr_q.size()) begin
        n_errors++;
        $display("FAIL rand_run%0d_acc_count: got %0d expected %0d", r, obs_addr_q.size(), exp_addr_q.size());
      end else begin
        for (int k = 0; k < exp_addr_q.size(); k++) begin
          n_checks++;
          if (obs_addr_q[k] !== exp_addr_q[k] || obs_wt_q[k] !== exp_wt_q[k]) begin
            n_errors++;
            $display("FAIL rand_run%0d_acc%0d: got addr=%0d w=%h expected %0d/%h", r, k, obs_addr_q[k], obs_wt_q[k], exp_addr_q[k], exp_wt_q[k]);
          end
        end
      end
      n_checks++;
      if (obs_pre_q.size() != 2 || obs_pre_q[0] !== exp_pre_q[0] || obs_pre_q[1] !== exp_pre_q[1]) begin
        n_errors++; $display("FAIL rand_run%0d_vmem: got %p expected %p", r, obs_pre_q, exp_pre_q);
      end
      n_checks++;
      if (obs_vmem_last !== 8'(model_vmem[1]) || obs_bad_ctrl != 0 || obs_done_after !== 1'b0) begin
        n_errors++;
        $display("FAIL rand_run%0d_end: got vmem1=%h bad=%0d done_after=%b expected %h/0/0", r, obs_vmem_last, obs_bad_ctrl, obs_done_after, 8'(model_vmem[1]));
      end
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        clear_vmem = 1'b1;
        @(negedge clk);
        clear_vmem = 1'b0;
        model_vmem[0] = 0;
        model_vmem[1] = 0;
      end
    end
  endtask

  initial begin
    rst_n      = 1'b1;
    start      = 1'b0;
    clear_vmem = 1'b0;
    in_spikes  = 4'b0000;
    for (int k = 0; k < 8; k++) wmem[k] = 8'h00;
    test_reset();
    test_all_zero();
    test_sub_threshold();
    test_firing();
    test_negative_weight();
    test_start_while_busy();
    test_clear_with_start();
    test_reset_mid_scan();
    test_random_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
